// File: rtl/sub32_pipe_pkg.sv
// Shared constants for the pipelined 32-bit subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sub32_pipe_pkg;

  localparam int SLICE_W    = 8;
  localparam int NUM_SLICES = 4;
  localparam int DATA_W     = SLICE_W * NUM_SLICES;

endpackage

// File: rtl/sub32_pipe_slice8.sv
// One 8-bit slice of a + ~b + cin using generate/propagate lookahead.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline decides when results are captured.
module sub_slice8
  import sub32_pipe_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b_n,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c7,
  output logic               is_zero
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  // Carry chain from per-bit generate/propagate; c[i] is the carry into bit i.
  always_comb begin
    g    = a & b_n;
    p    = a ^ b_n;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum     = p ^ c[SLICE_W-1:0];
    cout    = c[SLICE_W];
    c7      = c[SLICE_W-1];
    is_zero = (sum == '0);
  end

endmodule

// File: rtl/sub32_pipe.sv
// Pipelined 32-bit a - b - bin, one 8-bit slice resolved per stage, with borrow/overflow/zero flags.
// Latency: 4 cycles from accept to out_valid; 1 beat/cycle throughput.
// Backpressure: global stall when out_valid && !out_ready; every stage holds and in_ready drops.
module sub32_pipe
  import sub32_pipe_pkg::*;
#(
  // Only 4 is supported: the datapath below is built for exactly four 8-bit slices.
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              bout,
  output logic              ovf,
  output logic              zero
);

  logic [STAGES-1:0] vld;
  logic              stall;
  logic              adv;

  // Per-slice adder hookup.
  logic [SLICE_W-1:0]    s_a   [NUM_SLICES];
  logic [SLICE_W-1:0]    s_bn  [NUM_SLICES];
  logic [SLICE_W-1:0]    s_sum [NUM_SLICES];
  logic [NUM_SLICES-1:0] s_ci;
  logic [NUM_SLICES-1:0] s_co;
  logic [NUM_SLICES-1:0] s_c7;
  logic [NUM_SLICES-1:0] s_iz;

  // Stage 0 registers: slice 0 resolved, slices 1..3 of the operands still waiting.
  logic [23:0] a0, bn0;
  logic        c0, z0;
  logic [7:0]  d0;
  // Stage 1 registers: slices 0..1 resolved.
  logic [15:0] a1, bn1;
  logic        c1, z1;
  logic [15:0] d1;
  // Stage 2 registers: slices 0..2 resolved.
  logic [7:0]  a2, bn2;
  logic        c2, z2;
  logic [23:0] d2;
  // Output stage.
  logic [DATA_W-1:0] diff_q;
  logic              bout_q, ovf_q, zero_q;

  // Only the top slice's carry-into-msb matters for overflow.
  logic unused_c7;
  assign unused_c7 = ^s_c7[NUM_SLICES-2:0];

  assign out_valid = vld[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

  // Each stage feeds its slice adder from the skewed operand lanes and the registered carry.
  // Subtraction is a + ~b + 1, so the incoming borrow enters as an inverted carry.
  always_comb begin
    s_a[0]  = a[7:0];
    s_bn[0] = ~b[7:0];
    s_ci[0] = ~bin;
    s_a[1]  = a0[7:0];
    s_bn[1] = bn0[7:0];
    s_ci[1] = c0;
    s_a[2]  = a1[7:0];
    s_bn[2] = bn1[7:0];
    s_ci[2] = c1;
    s_a[3]  = a2;
    s_bn[3] = bn2;
    s_ci[3] = c2;
  end

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    sub_slice8 u_slice (
      .a       (s_a[k]),
      .b_n     (s_bn[k]),
      .cin     (s_ci[k]),
      .sum     (s_sum[k]),
      .cout    (s_co[k]),
      .c7      (s_c7[k]),
      .is_zero (s_iz[k])
    );
  end

  // Valid bits advance together with the data; bubbles carry a 0 valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[STAGES-2:0], in_valid};
    end
  end

  // Stage 0: resolve slice 0 and skew the upper operand slices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0 <= '0; bn0 <= '0; c0 <= 1'b0; d0 <= '0; z0 <= 1'b0;
    end else if (adv) begin
      a0  <= a[31:8];
      bn0 <= ~b[31:8];
      c0  <= s_co[0];
      d0  <= s_sum[0];
      z0  <= s_iz[0];
    end
  end

  // Stage 1: resolve slice 1, carry the lower result along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= '0; bn1 <= '0; c1 <= 1'b0; d1 <= '0; z1 <= 1'b0;
    end else if (adv) begin
      a1  <= a0[23:8];
      bn1 <= bn0[23:8];
      c1  <= s_co[1];
      d1  <= {s_sum[1], d0};
      z1  <= z0 & s_iz[1];
    end
  end

  // Stage 2: resolve slice 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a2 <= '0; bn2 <= '0; c2 <= 1'b0; d2 <= '0; z2 <= 1'b0;
    end else if (adv) begin
      a2  <= a1[15:8];
      bn2 <= bn1[15:8];
      c2  <= s_co[2];
      d2  <= {s_sum[2], d1};
      z2  <= z1 & s_iz[2];
    end
  end

  // Output stage: final slice plus flags; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0; bout_q <= 1'b0; ovf_q <= 1'b0; zero_q <= 1'b0;
    end else if (adv) begin
      diff_q <= {s_sum[3], d2};
      bout_q <= ~s_co[3];
      ovf_q  <= s_c7[3] ^ s_co[3];
      zero_q <= z2 & s_iz[3];
    end
  end

endmodule

// File: tb/tb_sub32_pipe.sv
module tb_sub32_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  always #5 clk = ~clk;

  sub32_pipe #(.STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  exp_t exp_q[$];
  exp_t forced;
  vec_t tbl[8];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_lat    = 1'b0;
  bit   use_forced = 1'b0;
  bit   out_fire   = 1'b0;
  bit   prev_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: plain wide arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb, input logic bi);
    exp_t e;
    logic [32:0]        u;
    logic signed [33:0] s;
    u = {1'b0, aa} - {1'b0, bb} - {32'd0, bi};
    s = $signed({aa[31], aa[31], aa}) - $signed({bb[31], bb[31], bb}) - $signed({33'd0, bi});
    e.d   = u[31:0];
    e.bo  = u[32];
    e.ov  = (s[33:31] != 3'b000) && (s[33:31] != 3'b111);
    e.z   = (u[31:0] == 32'd0);
    e.acc = 0;
    return e;
  endfunction

  // One clock: observe at the falling edge, then let the rising edge happen.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    out_fire = out_valid && out_ready;
    if (prev_stall) chk("stall_keeps_valid", out_valid, 1'b1);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out got diff=%0h want no result (cycle %0d)", diff, cyc);
      end else begin
        e = exp_q[0];
        chk("diff", diff, e.d);
        chk("bout", bout, e.bo);
        chk("ovf", ovf, e.ov);
        chk("zero", zero, e.z);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (chk_lat) chk("latency", cyc - e.acc, 4);
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    if (in_valid && in_ready) begin
      e = use_forced ? forced : model(a, b, bin);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    chk("drain_left", exp_q.size(), 0);
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, last;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_diff", diff, 32'd0);
    chk("rst_flags", {bout, ovf, zero}, 3'b000);
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready_no_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, one beat each, with latency checked.
    chk_lat    = 1'b1;
    use_forced = 1'b1;
    for (int i = 0; i < 8; i++) begin
      forced   = '{tbl[i].d, tbl[i].bo, tbl[i].ov, tbl[i].z, 0};
      a        = tbl[i].a;
      b        = tbl[i].b;
      bin      = tbl[i].bi;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int j = 0; j < 6; j++) step();
      chk("vec_done", exp_q.size(), 0);
    end
    use_forced = 1'b0;

    // Eight back-to-back beats must emerge on eight consecutive cycles.
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 8);
      a   = $urandom;
      b   = $urandom;
      bin = 1'($urandom_range(0, 1));
      step();
      if (out_fire) begin
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    chk("b2b_count", n, 8);
    chk("b2b_span", last - first, 7);

    // Full pipeline, consumer stalls five cycles.
    chk_lat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      step();
    end
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; bin = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      if (exp_q.size() > 0) chk("stall_hold_diff", diff, exp_q[0].d);
      chk("stall_q_size", exp_q.size(), 4);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_diff", diff, 32'd0);
    chk("midrst_flags", {bout, ovf, zero}, 3'b000);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk_lat  = 1'b1;
    in_valid = 1'b1;
    a = 32'h0000_0010; b = 32'h0000_0020; bin = 1'b0;
    step();
    drain();

    // Randomised traffic with random backpressure.
    chk_lat = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       a = 32'h0000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      bin = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub32_pipe.md
SUB32_PIPE -- requirements
Module: sub32_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 4, meaning the number of pipeline stages; 4 is the only supported value, and each stage resolves one 8-bit slice.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-006 SHALL have port a, input, 32 bits: minuend.
REQ-007 SHALL have port b, input, 32 bits: subtrahend.
REQ-008 SHALL have port bin, input, 1 bit: borrow-in.
REQ-009 SHALL have port out_valid, output, 1 bit: the result beat is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-011 SHALL have port diff, output, 32 bits: a - b - bin, modulo 2^32.
REQ-012 SHALL have port bout, output, 1 bit: unsigned borrow-out, 1 when a < b + bin.
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-014 SHALL have port zero, output, 1 bit: 1 when diff == 0.

Function
REQ-015 SHALL compute each 8-bit slice as a + ~b + cin with per-bit generate/propagate lookahead; stage 0 uses cin = ~bin, and stage k uses cin = carry-out of stage k-1.
REQ-016 SHALL register the carry between stages; the upper operand slices SHALL be skew-delayed and the lower diff slices de-skew-delayed so that all 32 result bits of one beat emerge together.
REQ-017 SHALL derive bout = ~(final carry-out) and ovf = carry into bit 31 XOR carry out of bit 31.
REQ-018 SHALL accumulate zero as a per-stage AND of "slice == 0" carried down the pipeline.
REQ-019 SHALL accept a beat when in_valid && in_ready, and SHALL present its result on out_valid exactly STAGES cycles later if no stall occurs (latency 4).
REQ-020 SHALL use a global stall, stall = out_valid && !out_ready; while stalled, all stage registers and valid bits SHALL hold.
REQ-021 SHALL drive in_ready = !stall, combinational from out_valid and out_ready only and independent of in_valid.
REQ-022 SHALL hold diff, bout, ovf and zero stable while out_valid && !out_ready.
REQ-023 SHALL sustain a throughput of 1 beat per cycle when out_ready is held at 1; back-to-back beats SHALL NOT interfere.
REQ-024 SHALL propagate a bubble, with its valid bit at 0, when in_valid = 0 at an accept cycle; bubbles SHALL NOT raise out_valid.
REQ-025 SHALL treat simultaneous accept and output handshakes in one cycle as an advance of the whole pipeline.

Reset
REQ-026 SHALL, while rst_n = 0, immediately clear all stage valid bits, so that out_valid = 0 and in_ready = 1.
REQ-027 SHALL hold diff, bout, ovf and zero at 0 during reset.
REQ-028 SHALL discard all in-flight beats when reset asserts mid-operation; no result of a pre-reset beat SHALL appear after release.
REQ-029 SHALL synchronise reset deassertion externally; the first beat SHALL be accepted on the first clk edge with rst_n = 1.

Structure
REQ-030 SHALL place SLICE_W = 8 and NUM_SLICES = 4 as constants in a shared package.
REQ-031 SHALL implement one combinational 8-bit lookahead slice sub-module, sub_slice8, with inputs a, ~b and cin and outputs sum[7:0], cout, c7 (the carry into bit 7) and is_zero; it SHALL be instantiated once per stage.

Verification
REQ-032 SHALL cover: a=0x0000_0005, b=0x0000_0003, bin=0 -> after 4 cycles diff=0x0000_0002, bout=0, ovf=0, zero=0.
REQ-033 SHALL cover: a=0x0000_0000, b=0x0000_0001, bin=0 -> diff=0xFFFF_FFFF, bout=1, ovf=0, zero=0 (full borrow ripple through all stages).
REQ-034 SHALL cover: a=0x8000_0000, b=0x0000_0001 -> diff=0x7FFF_FFFF, ovf=1, bout=0; and a=0x1234_5678, b=0x1234_5677, bin=1 -> diff=0, zero=1.
REQ-035 SHALL cover: 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles with results in order.
REQ-036 SHALL cover: out_ready=0 for 5 cycles with a full pipeline -> in_ready=0, outputs held, no beat lost or duplicated after release.
REQ-037 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, and no stale result after release.
